// File: rtl/csr_bus_arb_pkg.sv
// rtl/csr_bus_arb_pkg.sv - shared types and constants for the CSR bus arbiter
package csr_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam logic [31:0] CSR_RD_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic REQ_JTAG = 1'b0;
    localparam logic REQ_SEQ  = 1'b1;

endpackage

// File: rtl/csr_bus_arb.sv
// rtl/csr_bus_arb.sv - two-requester round-robin arbiter in front of the csr_ctrl access port
module csr_bus_arb
    import csr_bus_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic              m0_read,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic              m1_read,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] csr_wr_rd_addr,
    output logic              csr_wr_en,
    output logic              csr_rd_en,
    output logic [DATA_W-1:0] csr_wr_data,
    input  logic [DATA_W-1:0] csr_rd_datain,
    input  logic              csr_rd_dvalid,

    output logic              rd_timeout_err
);

    localparam int              CNT_W    = $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t              state;
    state_t              state_d;
    logic                grant;
    logic                grant_d;
    logic                rr_last;
    logic                op_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt;
    logic                req0;
    logic                req1;
    logic                rsp_fire;
    logic                rsp_err;
    logic [DATA_W-1:0]   rsp_data;

    assign req0 = m0_write | m0_read;
    assign req1 = m1_write | m1_read;

    // Round-robin pick: on a tie the requester not served last wins
    always_comb begin
        grant_d = REQ_JTAG;
        if (req0 && req1) begin
            grant_d = ~rr_last;
        end else if (req1) begin
            grant_d = REQ_SEQ;
        end
    end

    // Read response source: real data always beats the timeout in the same cycle
    always_comb begin
        rsp_fire = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = csr_rd_datain;
        if (state == RDWAIT) begin
            if (csr_rd_dvalid) begin
                rsp_fire = 1'b1;
            end else if (cnt == CNT_LAST) begin
                rsp_fire = 1'b1;
                rsp_err  = 1'b1;
                rsp_data = DATA_W'(CSR_RD_ERR_DATA);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req0 || req1) state_d = ISSUE;
            ISSUE:   state_d = op_wr ? IDLE : RDWAIT;
            RDWAIT:  if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Grant capture, timeout counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant            <= REQ_JTAG;
            rr_last          <= 1'b1;
            op_wr            <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            cnt              <= '0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            rd_timeout_err   <= 1'b0;
        end else begin
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            rd_timeout_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant   <= grant_d;
                        rr_last <= grant_d;
                        addr_q  <= (grant_d == REQ_SEQ) ? m1_addr  : m0_addr;
                        wdata_q <= (grant_d == REQ_SEQ) ? m1_wdata : m0_wdata;
                        op_wr   <= (grant_d == REQ_SEQ) ? m1_write : m0_write;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                RDWAIT: begin
                    if (rsp_fire) begin
                        rd_timeout_err <= rsp_err;
                        if (grant == REQ_SEQ) begin
                            m1_readdata      <= rsp_data;
                            m1_readdatavalid <= 1'b1;
                        end else begin
                            m0_readdata      <= rsp_data;
                            m0_readdatavalid <= 1'b1;
                        end
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign csr_wr_rd_addr = addr_q;
    assign csr_wr_data    = wdata_q;
    assign csr_wr_en      = (state == ISSUE) &  op_wr;
    assign csr_rd_en      = (state == ISSUE) & ~op_wr;

    assign m0_waitrequest = req0 & ~((state == ISSUE) & (grant == REQ_JTAG));
    assign m1_waitrequest = req1 & ~((state == ISSUE) & (grant == REQ_SEQ));

endmodule

// File: tb/tb_csr_bus_arb.sv
// tb/tb_csr_bus_arb.sv - directed self-checking bench for csr_bus_arb
module tb_csr_bus_arb;
    import csr_bus_arb_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int RD_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_write, m0_read, m1_write, m1_read;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] csr_wr_rd_addr;
    logic              csr_wr_en, csr_rd_en;
    logic [DATA_W-1:0] csr_wr_data;
    logic [DATA_W-1:0] csr_rd_datain;
    logic              csr_rd_dvalid;
    logic              rd_timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csr_bus_arb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_addr          (m0_addr),
        .m0_write         (m0_write),
        .m0_read          (m0_read),
        .m0_wdata         (m0_wdata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_addr          (m1_addr),
        .m1_write         (m1_write),
        .m1_read          (m1_read),
        .m1_wdata         (m1_wdata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .csr_wr_rd_addr   (csr_wr_rd_addr),
        .csr_wr_en        (csr_wr_en),
        .csr_rd_en        (csr_rd_en),
        .csr_wr_data      (csr_wr_data),
        .csr_rd_datain    (csr_rd_datain),
        .csr_rd_dvalid    (csr_rd_dvalid),
        .rd_timeout_err   (rd_timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"},  csr_wr_en, 0);
        chk({tag, "_rd_en"},  csr_rd_en, 0);
        chk({tag, "_addr"},   csr_wr_rd_addr, 0);
        chk({tag, "_wdata"},  csr_wr_data, 0);
        chk({tag, "_rd0"},    m0_readdata, 0);
        chk({tag, "_rd1"},    m1_readdata, 0);
        chk({tag, "_rdv0"},   m0_readdatavalid, 0);
        chk({tag, "_rdv1"},   m1_readdatavalid, 0);
        chk({tag, "_err"},    rd_timeout_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic flag;
        int   w0, w1, w0_max, w1_max;
        logic [ADDR_W-1:0] exp_addr;

        rst_n = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
        m0_wdata = '0; m1_wdata = '0; csr_rd_datain = '0; csr_rd_dvalid = 0;
        tick();
        tick();

        // reset state
        check_all_zero("rst");
        chk("rst_wait0", m0_waitrequest, 0);
        chk("rst_wait1", m1_waitrequest, 0);
        rst_n = 1'b1;
        tick();

        // T1: m0 write 0x0010 <= 0xA5
        m0_addr = 16'h0010; m0_wdata = 32'h0000_00A5; m0_write = 1; settle();
        chk("t1_c0_wait0", m0_waitrequest, 1);
        chk("t1_c0_wr_en", csr_wr_en, 0);
        tick();
        chk("t1_c1_wr_en", csr_wr_en, 1);
        chk("t1_c1_rd_en", csr_rd_en, 0);
        chk("t1_c1_addr",  csr_wr_rd_addr, 16'h0010);
        chk("t1_c1_data",  csr_wr_data, 32'h0000_00A5);
        chk("t1_c1_wait0", m0_waitrequest, 0);
        tick();
        m0_write = 0; settle();
        chk("t1_c2_wr_en", csr_wr_en, 0);
        chk("t1_c2_wait0", m0_waitrequest, 0);

        // T2: m1 read 0x0020, data returned 3 cycles after csr_rd_en
        tick();
        m1_addr = 16'h0020; m1_read = 1; settle();
        chk("t2_c0_wait1", m1_waitrequest, 1);
        tick();
        chk("t2_c1_rd_en", csr_rd_en, 1);
        chk("t2_c1_wr_en", csr_wr_en, 0);
        chk("t2_c1_addr",  csr_wr_rd_addr, 16'h0020);
        chk("t2_c1_wait1", m1_waitrequest, 0);
        tick();
        m1_read = 0;
        tick();
        tick();
        csr_rd_datain = 32'h1234_5678; csr_rd_dvalid = 1; settle();
        chk("t2_c4_rdv1", m1_readdatavalid, 0);
        tick();
        csr_rd_dvalid = 0; settle();
        chk("t2_c5_rdv1", m1_readdatavalid, 1);
        chk("t2_c5_rd1",  m1_readdata, 32'h1234_5678);
        chk("t2_c5_rdv0", m0_readdatavalid, 0);
        chk("t2_c5_rd0",  m0_readdata, 0);
        tick();
        chk("t2_c6_rdv1", m1_readdatavalid, 0);
        chk("t2_c6_rd1",  m1_readdata, 32'h1234_5678);

        // T3: continuous requests from reset alternate 0,1,0,1
        rst_n = 0; tick(); rst_n = 1;
        m0_addr = 16'h0100; m1_addr = 16'h0200; m0_write = 1; m1_write = 1; settle();
        w0 = m0_waitrequest ? 1 : 0; w1 = m1_waitrequest ? 1 : 0;
        w0_max = w0; w1_max = w1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                exp_addr = (((k - 1) / 2) % 2 == 0) ? 16'h0100 : 16'h0200;
                chk($sformatf("t3_c%0d_wr_en", k), csr_wr_en, 1);
                chk($sformatf("t3_c%0d_addr", k), csr_wr_rd_addr, exp_addr);
                chk($sformatf("t3_c%0d_wait0", k), m0_waitrequest, exp_addr == 16'h0200);
            end else begin
                chk($sformatf("t3_c%0d_wr_en", k), csr_wr_en, 0);
            end
            w0 = m0_waitrequest ? w0 + 1 : 0;
            w1 = m1_waitrequest ? w1 + 1 : 0;
            if (w0 > w0_max) w0_max = w0;
            if (w1 > w1_max) w1_max = w1;
        end
        m0_write = 0; m1_write = 0;
        chk("t3_maxwait0", w0_max <= 4, 1);
        chk("t3_maxwait1", w1_max <= 4, 1);
        tick();
        chk("t3_withdrawn_wr_en", csr_wr_en, 0);

        // T4: m0 read with no response -> timeout after 64 RDWAIT cycles
        m0_addr = 16'h0030; m0_read = 1; settle();
        tick();
        chk("t4_c1_rd_en", csr_rd_en, 1);
        tick();
        m0_read = 0; settle();
        flag = m0_readdatavalid | rd_timeout_err;
        for (int c = 3; c <= 65; c++) begin
            tick();
            flag = flag | m0_readdatavalid | rd_timeout_err;
        end
        chk("t4_no_early_rsp", flag, 0);
        tick();
        chk("t4_c66_rdv0", m0_readdatavalid, 1);
        chk("t4_c66_rd0",  m0_readdata, 32'hDEAD_BEEF);
        chk("t4_c66_err",  rd_timeout_err, 1);
        tick();
        chk("t4_c67_err",  rd_timeout_err, 0);
        chk("t4_c67_rdv0", m0_readdatavalid, 0);

        // T5: real data in the same cycle as the last count wins, no error
        m1_addr = 16'h0034; m1_read = 1; settle();
        tick();
        tick();
        m1_read = 0;
        for (int c = 3; c <= 65; c++) tick();
        csr_rd_datain = 32'hCAFE_F00D; csr_rd_dvalid = 1;
        tick();
        csr_rd_dvalid = 0; settle();
        chk("t5_rdv1", m1_readdatavalid, 1);
        chk("t5_rd1",  m1_readdata, 32'hCAFE_F00D);
        chk("t5_err",  rd_timeout_err, 0);
        chk("t5_rd0_hold", m0_readdata, 32'hDEAD_BEEF);

        // T6: reset during RDWAIT aborts the read
        tick();
        m1_addr = 16'h0040; m1_read = 1; settle();
        tick();
        tick();
        m1_read = 0;
        tick();
        rst_n = 0; settle();
        check_all_zero("t6_rst");
        tick();
        rst_n = 1; settle();
        csr_rd_datain = 32'h0000_0055; csr_rd_dvalid = 1;
        tick();
        csr_rd_dvalid = 0;
        flag = m0_readdatavalid | m1_readdatavalid;
        for (int c = 0; c < 3; c++) begin
            tick();
            flag = flag | m0_readdatavalid | m1_readdatavalid | csr_rd_en | csr_wr_en;
        end
        chk("t6_no_rsp", flag, 0);
        m0_addr = 16'h0100; m1_addr = 16'h0200; m0_write = 1; m1_write = 1; settle();
        tick();
        chk("t6_tie_wr_en", csr_wr_en, 1);
        chk("t6_tie_addr",  csr_wr_rd_addr, 16'h0100);
        tick();
        m0_write = 0; m1_write = 0;
        tick();

        // T7: write and read together -> write only
        m0_addr = 16'h0050; m0_wdata = 32'h0000_0077; m0_write = 1; m0_read = 1; settle();
        tick();
        chk("t7_wr_en", csr_wr_en, 1);
        chk("t7_rd_en", csr_rd_en, 0);
        tick();
        m0_write = 0; m0_read = 0;
        flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            csr_rd_dvalid = (c == 1);
            tick();
            flag = flag | csr_rd_en | m0_readdatavalid;
        end
        csr_rd_dvalid = 0;
        chk("t7_no_read", flag, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
